tcam_match_iterator: RTL and testbench

- Downstream stage of the 16-entry ternary match memory.
- Consumes the memory's per-entry match vector (bit i = entry i matched the lookup value under its don't-care mask).
- Emits every matching entry index in priority order, lowest index first, one per handshake beat.
- Flags the last hit and reports miss and hit count, so the next stage (action lookup) handles single and multi-match lookups uniformly.

---
 rtl/tcam_match_iterator_if.sv | 33 +++
 rtl/tcam_match_iterator.sv | 124 ++++++++++++
 tb/tb_tcam_match_iterator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tcam_match_iterator_if.sv
// Handshake bundle between the ternary match memory, the match iterator and
// the action-lookup stage. The slave modport is the iterator's view.
interface tcam_match_iterator_if #(
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 5
);
    // Upstream: match vector from the memory
    logic [N_ENTRIES-1:0] match_vec;
    logic                 match_valid;
    logic                 match_ready;
    logic                 flush;

    // Downstream: one hit index per beat
    logic [IDX_W-1:0]     idx;
    logic                 idx_valid;
    logic                 idx_ready;
    logic                 idx_last;
    logic [CNT_W-1:0]     hit_count;
    logic                 miss;

    // Driver side: memory upstream plus the consumer's ready
    modport master (
        output match_vec, match_valid, flush, idx_ready,
        input  match_ready, idx, idx_valid, idx_last, hit_count, miss
    );

    // Iterator side
    modport slave (
        input  match_vec, match_valid, flush, idx_ready,
        output match_ready, idx, idx_valid, idx_last, hit_count, miss
    );
endinterface

// File: rtl/tcam_match_iterator.sv
// Walks a TCAM match vector and emits every matching entry index, lowest
// first, one per idx handshake beat. Flags the last hit, reports the hit
// count of the accepted vector and pulses miss for an all-zero vector.
module tcam_match_iterator #(
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    tcam_match_iterator_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N_ENTRIES-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 idx_valid_q, idx_valid_d;
    logic                 idx_last_q, idx_last_d;
    logic [CNT_W-1:0]     hit_count_q, hit_count_d;
    logic                 miss_q, miss_d;
    logic                 accept;
    logic                 beat;

    // Position of the lowest set bit; 0 for an empty vector.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_ENTRIES-1:0] v);
        logic [IDX_W-1:0] pos;
        pos = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) pos = IDX_W'(i);
        end
        return pos;
    endfunction

    // Full popcount, no saturation.
    function automatic logic [CNT_W-1:0] popcount(input logic [N_ENTRIES-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Ready only in IDLE and never while reset is asserted.
    assign bus.match_ready = (state_q == IDLE) && !rst;
    assign bus.idx         = idx_q;
    assign bus.idx_valid   = idx_valid_q;
    assign bus.idx_last    = idx_last_q;
    assign bus.hit_count   = hit_count_q;
    assign bus.miss        = miss_q;

    // Next-state logic: accept, beat consumption and flush.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        pending_d   = pending_q;
        idx_valid_d = idx_valid_q;
        hit_count_d = hit_count_q;
        miss_d      = 1'b0;

        // A flush in IDLE suppresses a coincident vector.
        accept = bus.match_valid && bus.match_ready && !bus.flush;
        beat   = idx_valid_q && bus.idx_ready;

        if (state_q == IDLE) begin
            if (accept) begin
                hit_count_d = popcount(bus.match_vec);
                if (bus.match_vec != '0) begin
                    pending_d   = bus.match_vec;
                    idx_valid_d = 1'b1;
                    state_d     = BUSY;
                end else begin
                    miss_d = 1'b1;
                end
            end
        end else begin
            if (bus.flush) begin
                // Flush wins over a coincident beat: nothing is consumed.
                pending_d   = '0;
                idx_valid_d = 1'b0;
                state_d     = IDLE;
            end else if (beat) begin
                pending_d = pending_q & ~(N_ENTRIES'(1) << idx_q);
                if (idx_last_q) begin
                    idx_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        end

        // Outputs are registered, derived from the pending set of the next cycle.
        idx_d      = lowest_set(pending_d);
        idx_last_d = (popcount(pending_d) == CNT_W'(1));
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            idx_last_q  <= 1'b0;
            hit_count_q <= '0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            idx_last_q  <= idx_last_d;
            hit_count_q <= hit_count_d;
            miss_q      <= miss_d;
        end
    end

endmodule

// File: tb/tb_tcam_match_iterator.sv
// Directed bench for tcam_match_iterator. Inputs change and outputs are
// sampled on the falling edge, half a cycle away from the active edge.
module tb_tcam_match_iterator;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    tcam_match_iterator_if #(.N_ENTRIES(16), .IDX_W(4), .CNT_W(5)) bus ();

    tcam_match_iterator #(.N_ENTRIES(16), .IDX_W(4), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare the downstream view {idx_valid, idx, idx_last} against expectation.
    task automatic expect_out(input string name, input logic v, input logic [3:0] i, input logic l);
        tests_run++;
        if ({bus.idx_valid, bus.idx, bus.idx_last} !== {v, i, l}) begin
            tests_failed++;
            $display("FAIL %s: got valid=%b idx=%0d last=%b, want valid=%b idx=%0d last=%b",
                     name, bus.idx_valid, bus.idx, bus.idx_last, v, i, l);
        end
    endtask

    task automatic expect_side(input string name, input logic rdy, input logic [4:0] cnt, input logic m);
        tests_run++;
        if ({bus.match_ready, bus.hit_count, bus.miss} !== {rdy, cnt, m}) begin
            tests_failed++;
            $display("FAIL %s: got ready=%b hit_count=%0d miss=%b, want ready=%b hit_count=%0d miss=%b",
                     name, bus.match_ready, bus.hit_count, bus.miss, rdy, cnt, m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.match_vec = '0; bus.match_valid = 1'b0; bus.flush = 1'b0; bus.idx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_out("rst_out", 1'b0, 4'd0, 1'b0);
        expect_side("rst_side", 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        expect_out("idle_out", 1'b0, 4'd0, 1'b0);
        expect_side("idle_side", 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        expect_out("idle_quiet", 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_double_hit();
        bus.idx_ready = 1'b1;
        bus.match_vec = 16'h0C00; bus.match_valid = 1'b1;
        @(negedge clk);
        bus.match_valid = 1'b0;
        expect_out("dh_first", 1'b1, 4'd10, 1'b0);
        expect_side("dh_first_side", 1'b0, 5'd2, 1'b0);
        @(negedge clk);
        expect_out("dh_second", 1'b1, 4'd11, 1'b1);
        @(negedge clk);
        tests_run++;
        if ({bus.idx_valid, bus.match_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL dh_done: got valid=%b ready=%b, want valid=0 ready=1", bus.idx_valid, bus.match_ready);
        end
    endtask

    task automatic test_miss();
        bus.match_vec = 16'h0000; bus.match_valid = 1'b1;
        @(negedge clk);
        bus.match_valid = 1'b0;
        expect_out("miss_out", 1'b0, 4'd0, 1'b0);
        expect_side("miss_pulse", 1'b1, 5'd0, 1'b1);
        @(negedge clk);
        expect_out("miss_after_out", 1'b0, 4'd0, 1'b0);
        expect_side("miss_after", 1'b1, 5'd0, 1'b0);
    endtask

    task automatic test_backpressure();
        bus.idx_ready = 1'b0;
        bus.match_vec = 16'h8001; bus.match_valid = 1'b1;
        @(negedge clk);
        bus.match_valid = 1'b0;
        bus.match_vec = 16'h00F0;   // later changes must not leak in
        for (int c = 0; c < 3; c++) begin
            expect_out($sformatf("bp_stall%0d", c), 1'b1, 4'd0, 1'b0);
            if (c < 2) @(negedge clk);
        end
        expect_side("bp_side", 1'b0, 5'd2, 1'b0);
        bus.idx_ready = 1'b1;
        @(negedge clk);
        expect_out("bp_last", 1'b1, 4'd15, 1'b1);
        @(negedge clk);
        expect_out("bp_done", 1'b0, 4'd0, 1'b0);
    endtask

    // Abort a 16-hit vector after two beats, by flush or by reset.
    task automatic test_abort(input bit use_rst);
        string tag;
        tag = use_rst ? "rstmid" : "flush";
        bus.idx_ready = 1'b1;
        bus.match_vec = 16'hFFFF; bus.match_valid = 1'b1;
        @(negedge clk);
        bus.match_valid = 1'b0;
        expect_out({tag, "_b0"}, 1'b1, 4'd0, 1'b0);
        expect_side({tag, "_cnt16"}, 1'b0, 5'd16, 1'b0);
        @(negedge clk);
        expect_out({tag, "_b1"}, 1'b1, 4'd1, 1'b0);
        if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
        @(negedge clk);
        expect_out({tag, "_gone"}, 1'b0, 4'd0, 1'b0);
        if (use_rst) begin
            expect_side({tag, "_side"}, 1'b0, 5'd0, 1'b0);
            rst = 1'b0;
            #1;
        end
        bus.flush = 1'b0;
        expect_side({tag, "_ready"}, 1'b1, use_rst ? 5'd0 : 5'd16, 1'b0);
        bus.match_vec = 16'h0010; bus.match_valid = 1'b1;
        @(negedge clk);
        bus.match_valid = 1'b0;
        expect_out({tag, "_new"}, 1'b1, 4'd4, 1'b1);
        expect_side({tag, "_new_cnt"}, 1'b0, 5'd1, 1'b0);
        @(negedge clk);
        expect_out({tag, "_new_done"}, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_flush_idle();
        bus.flush = 1'b1;
        bus.match_vec = 16'h0300; bus.match_valid = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0; bus.match_valid = 1'b0;
        expect_out("fidle_out", 1'b0, 4'd0, 1'b0);
        expect_side("fidle_side", 1'b1, 5'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        bus.idx_ready = 1'b1;
        bus.match_vec = 16'h0004; bus.match_valid = 1'b1;
        @(negedge clk);
        expect_out("b2b_only", 1'b1, 4'd2, 1'b1);
        bus.match_vec = 16'h0020;   // offered during the final beat
        #1;
        tests_run++;
        if (bus.match_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_busy_ready: got %b want 0", bus.match_ready);
        end
        @(negedge clk);
        expect_out("b2b_not_taken", 1'b0, 4'd0, 1'b0);
        expect_side("b2b_ready", 1'b1, 5'd1, 1'b0);
        @(negedge clk);
        bus.match_valid = 1'b0;
        expect_out("b2b_second", 1'b1, 4'd5, 1'b1);
        @(negedge clk);
        expect_out("b2b_done", 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_double_hit();
        test_miss();
        test_backpressure();
        test_abort(1'b0);
        test_flush_idle();
        test_abort(1'b1);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
